// File: rtl/ex_mem_pkg.sv
// Shared widths, zero constants and action decode for the EX/MEM pipeline register.
package ex_mem_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 8;
    localparam int HILO_W     = 64;
    localparam int CNT_W      = 2;

    localparam logic [REG_W-1:0]      ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
    localparam logic [ALUOP_W-1:0]    EXE_NOP_OP   = '0;

    typedef enum logic [1:0] {
        ACT_FLUSH,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_CAPTURE
    } action_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [REG_W-1:0]      wdata;
        logic                  whilo;
        logic [REG_W-1:0]      hi;
        logic [REG_W-1:0]      lo;
        logic [ALUOP_W-1:0]    aluop;
        logic [REG_W-1:0]      mem_addr;
        logic [REG_W-1:0]      reg2;
        logic                  is_in_delayslot;
        logic [REG_W-1:0]      inst_addr;
        logic                  valid;
    } mem_slot_t;

    localparam mem_slot_t EMPTY_SLOT = '{
        wd: NOP_REG_ADDR, wreg: 1'b0, wdata: ZERO_WORD, whilo: 1'b0,
        hi: ZERO_WORD, lo: ZERO_WORD, aluop: EXE_NOP_OP, mem_addr: ZERO_WORD,
        reg2: ZERO_WORD, is_in_delayslot: 1'b0, inst_addr: ZERO_WORD, valid: 1'b0
    };

    // Flush beats everything; a held MEM stage ignores the EX stall.
    function automatic action_e decode_action(input logic flush, input logic stall,
                                              input logic stall_next);
        if (flush)           return ACT_FLUSH;
        else if (stall_next) return ACT_HOLD;
        else if (stall)      return ACT_BUBBLE;
        else                 return ACT_CAPTURE;
    endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with flush/hold/bubble control and madd/msub
// partial-product feedback to EX.
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall,
    input  logic                  stall_next,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [REG_W-1:0]      ex_wdata,
    input  logic                  ex_whilo,
    input  logic [REG_W-1:0]      ex_hi,
    input  logic [REG_W-1:0]      ex_lo,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [REG_W-1:0]      ex_mem_addr,
    input  logic [REG_W-1:0]      ex_reg2,
    input  logic                  ex_is_in_delayslot,
    input  logic [REG_W-1:0]      ex_inst_addr,
    input  logic [HILO_W-1:0]     ex_hilo_temp,
    input  logic [CNT_W-1:0]      ex_cnt,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [REG_W-1:0]      mem_wdata,
    output logic                  mem_whilo,
    output logic [REG_W-1:0]      mem_hi,
    output logic [REG_W-1:0]      mem_lo,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [REG_W-1:0]      mem_mem_addr,
    output logic [REG_W-1:0]      mem_reg2,
    output logic                  mem_is_in_delayslot,
    output logic [REG_W-1:0]      mem_inst_addr,
    output logic                  mem_valid,
    output logic [HILO_W-1:0]     hilo_temp_o,
    output logic [CNT_W-1:0]      cnt_o
);

    mem_slot_t             slot_d, slot_q;
    logic [HILO_W-1:0]     hilo_temp_d, hilo_temp_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;
    action_e               action;
    mem_slot_t             ex_slot;

    assign action  = decode_action(flush, stall, stall_next);
    assign ex_slot = '{
        wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, whilo: ex_whilo,
        hi: ex_hi, lo: ex_lo, aluop: ex_aluop, mem_addr: ex_mem_addr,
        reg2: ex_reg2, is_in_delayslot: ex_is_in_delayslot,
        inst_addr: ex_inst_addr, valid: 1'b1
    };

    always_comb begin
        slot_d      = slot_q;
        hilo_temp_d = hilo_temp_q;
        cnt_d       = cnt_q;
        case (action)
            ACT_FLUSH: begin
                slot_d      = EMPTY_SLOT;
                hilo_temp_d = '0;
                cnt_d       = '0;
            end
            ACT_HOLD: ;
            // EX is stalled on its own multi-cycle op: keep feeding its partial result back.
            ACT_BUBBLE: begin
                slot_d      = EMPTY_SLOT;
                hilo_temp_d = ex_hilo_temp;
                cnt_d       = ex_cnt;
            end
            ACT_CAPTURE: begin
                slot_d      = ex_slot;
                hilo_temp_d = '0;
                cnt_d       = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q      <= EMPTY_SLOT;
            hilo_temp_q <= '0;
            cnt_q       <= '0;
        end else begin
            slot_q      <= slot_d;
            hilo_temp_q <= hilo_temp_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_wd              = slot_q.wd;
    assign mem_wreg            = slot_q.wreg;
    assign mem_wdata           = slot_q.wdata;
    assign mem_whilo           = slot_q.whilo;
    assign mem_hi              = slot_q.hi;
    assign mem_lo              = slot_q.lo;
    assign mem_aluop           = slot_q.aluop;
    assign mem_mem_addr        = slot_q.mem_addr;
    assign mem_reg2            = slot_q.reg2;
    assign mem_is_in_delayslot = slot_q.is_in_delayslot;
    assign mem_inst_addr       = slot_q.inst_addr;
    assign mem_valid           = slot_q.valid;
    assign hilo_temp_o         = hilo_temp_q;
    assign cnt_o               = cnt_q;

endmodule
